// File: rtl/run_control.sv
// Run/step/halt sequencer: owns the 3-bit phase counter, run state, datapath enable and retired-instruction count; all outputs registered (Moore).
// No backpressure: start/step/stop are single-cycle pulses. Optional breakpoint logic is enabled with `define BREAKPOINT_EN.
module run_control #(
  parameter int AWIDTH     = 5,
  parameter int ICNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  stop,
  input  logic                  halt,
  input  logic [AWIDTH-1:0]     pc_addr,
  input  logic [AWIDTH-1:0]     bp_addr,
  input  logic                  bp_valid,
  output logic [2:0]            phase,
  output logic                  cpu_en,
  output logic [1:0]            run_state,
  output logic                  busy,
  output logic [ICNT_WIDTH-1:0] instr_count,
  output logic                  bp_hit
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [ICNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  bp_match;
  logic                  bp_set, bp_clr;

`ifdef BREAKPOINT_EN
  logic bp_hit_q;

  // PC has already advanced past the phase-4 increment, so a hit stops before fetching bp_addr
  assign bp_match = bp_valid && (pc_addr == bp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bp_hit_q <= 1'b0;
    else if (bp_set) bp_hit_q <= 1'b1;
    else if (bp_clr) bp_hit_q <= 1'b0;
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc_addr, bp_addr, bp_valid, bp_set, bp_clr};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 3'd0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    bp_set      = 1'b0;
    bp_clr      = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        phase_d     = 3'd0;
        stop_pend_d = 1'b0;
        if (start) begin
          state_d = RUN;
          bp_clr  = (state_q == HALTED);
        end else if (step) begin
          state_d = STEP;
          bp_clr  = (state_q == HALTED);
        end
      end
      default: begin
        phase_d = phase_q + 3'd1;
        if (stop) stop_pend_d = 1'b1;
        if (phase_q == 3'd4 && halt) begin
          // HLT retires early: phases 5-7 are skipped
          state_d     = HALTED;
          phase_d     = 3'd0;
          cnt_d       = cnt_q + ICNT_WIDTH'(1);
          stop_pend_d = 1'b0;
        end else if (phase_q == 3'd7) begin
          cnt_d       = cnt_q + ICNT_WIDTH'(1);
          stop_pend_d = 1'b0;
          if (state_q == RUN && bp_match) begin
            state_d = HALTED;
            bp_set  = 1'b1;
          end else if (state_q == STEP || stop || stop_pend_q) begin
            state_d = HALTED;
          end
        end
      end
    endcase
  end

  assign phase       = phase_q;
  assign run_state   = state_q;
  assign cpu_en      = (state_q == RUN) || (state_q == STEP);
  assign busy        = cpu_en;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: expected snapshots are queued as each stimulus step is driven and checked after the edge.
module tb_run_control;

`ifdef BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic       clk, rst, start, step, stop, halt, bp_valid;
  logic [4:0] pc_addr, bp_addr;
  logic [2:0] phase;
  logic       cpu_en, busy, bp_hit;
  logic [1:0] run_state;
  logic [3:0] instr_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [2:0] ph;
    logic [3:0] cnt;
    logic       bp;
  } exp_t;

  exp_t sbq[$];

  run_control #(.AWIDTH(5), .ICNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop), .halt(halt),
    .pc_addr(pc_addr), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .phase(phase), .cpu_en(cpu_en), .run_state(run_state), .busy(busy),
    .instr_count(instr_count), .bp_hit(bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic [2:0] ph,
                      input logic [3:0] cnt, input logic bp);
    exp_t e;
    e.tag = tag; e.st = st; e.ph = ph; e.cnt = cnt; e.bp = bp;
    sbq.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic een;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty got=%0d required=nonzero", sbq.size());
    end
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      een = (e.st == 2'b01) || (e.st == 2'b10);
      checks++;
      assert (run_state === e.st) else begin
        failures++; $error("FAIL %s run_state got=%0d required=%0d", e.tag, run_state, e.st);
      end
      checks++;
      assert (phase === e.ph) else begin
        failures++; $error("FAIL %s phase got=%0d required=%0d", e.tag, phase, e.ph);
      end
      checks++;
      assert (cpu_en === een) else begin
        failures++; $error("FAIL %s cpu_en got=%0d required=%0d", e.tag, cpu_en, een);
      end
      checks++;
      assert (busy === een) else begin
        failures++; $error("FAIL %s busy got=%0d required=%0d", e.tag, busy, een);
      end
      checks++;
      assert (instr_count === e.cnt) else begin
        failures++; $error("FAIL %s instr_count got=%0d required=%0d", e.tag, instr_count, e.cnt);
      end
      checks++;
      assert (bp_hit === e.bp) else begin
        failures++; $error("FAIL %s bp_hit got=%0d required=%0d", e.tag, bp_hit, e.bp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0; halt = 1'b0;
    bp_valid = 1'b0; pc_addr = 5'd0; bp_addr = 5'd0;
    tick(); tick();
    push("reset", 2'b00, 3'd0, 4'd0, 1'b0); chk();
    rst = 1'b0;

    // free run; start+step mid-instruction must be ignored
    start = 1'b1; push("start", 2'b01, 3'd0, 4'd0, 1'b0); tick(); start = 1'b0; chk();
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin start = 1'b1; step = 1'b1; end
      push("run_ph", 2'b01, 3'(i), 4'd0, 1'b0); tick(); start = 1'b0; step = 1'b0; chk();
    end
    push("boundary1", 2'b01, 3'd0, 4'd1, 1'b0); tick(); chk();
    for (int i = 1; i <= 8; i++) begin
      push("run2", 2'b01, 3'(i % 8), (i == 8) ? 4'd2 : 4'd1, 1'b0); tick(); chk();
    end

    // halt ignored at phase 2, honoured at phase 4
    push("run3_ph1", 2'b01, 3'd1, 4'd2, 1'b0); tick(); chk();
    push("run3_ph2", 2'b01, 3'd2, 4'd2, 1'b0); tick(); chk();
    halt = 1'b1; push("halt_ph2_ign", 2'b01, 3'd3, 4'd2, 1'b0); tick(); halt = 1'b0; chk();
    push("run3_ph4", 2'b01, 3'd4, 4'd2, 1'b0); tick(); chk();
    halt = 1'b1; push("halt_ph4", 2'b11, 3'd0, 4'd3, 1'b0); tick(); halt = 1'b0; chk();
    stop = 1'b1; push("halted_stop_ign", 2'b11, 3'd0, 4'd3, 1'b0); tick(); stop = 1'b0; chk();

    // stop at phase 2 completes the instruction
    start = 1'b1; push("restart", 2'b01, 3'd0, 4'd3, 1'b0); tick(); start = 1'b0; chk();
    push("stop_ph1", 2'b01, 3'd1, 4'd3, 1'b0); tick(); chk();
    push("stop_ph2", 2'b01, 3'd2, 4'd3, 1'b0); tick(); chk();
    stop = 1'b1; push("stop_ph3", 2'b01, 3'd3, 4'd3, 1'b0); tick(); stop = 1'b0; chk();
    for (int i = 4; i <= 7; i++) begin
      push("stop_run", 2'b01, 3'(i), 4'd3, 1'b0); tick(); chk();
    end
    push("stop_halt", 2'b11, 3'd0, 4'd4, 1'b0); tick(); chk();

    // two single steps
    for (int s = 0; s < 2; s++) begin
      step = 1'b1; push("step0", 2'b10, 3'd0, 4'(4 + s), 1'b0); tick(); step = 1'b0; chk();
      for (int i = 1; i <= 7; i++) begin
        push("step_ph", 2'b10, 3'(i), 4'(4 + s), 1'b0); tick(); chk();
      end
      push("step_done", 2'b11, 3'd0, 4'(5 + s), 1'b0); tick(); chk();
    end

    // breakpoint: disarmed match does nothing, armed match halts
    pc_addr = 5'd5; bp_addr = 5'd5; bp_valid = 1'b0;
    start = 1'b1; push("bp_start", 2'b01, 3'd0, 4'd6, 1'b0); tick(); start = 1'b0; chk();
    for (int i = 1; i <= 7; i++) begin
      push("bp_run", 2'b01, 3'(i), 4'd6, 1'b0); tick(); chk();
    end
    push("bp_invalid_nohalt", 2'b01, 3'd0, 4'd7, 1'b0); tick(); chk();
    bp_valid = 1'b1; pc_addr = 5'd3;
    for (int i = 1; i <= 7; i++) begin
      push("bp_run2", 2'b01, 3'(i), 4'd7, 1'b0); tick(); chk();
    end
    pc_addr = 5'd5;
    push("bp_boundary", BP ? 2'b11 : 2'b01, 3'd0, 4'd8, BP); tick(); chk();
`ifdef BREAKPOINT_EN
    start = 1'b1; pc_addr = 5'd6;
    push("bp_resume", 2'b01, 3'd0, 4'd8, 1'b0); tick(); start = 1'b0; chk();
    for (int i = 1; i <= 7; i++) begin
      push("bp_resume_run", 2'b01, 3'(i), 4'd8, 1'b0); tick(); chk();
    end
    push("bp_no_rehit", 2'b01, 3'd0, 4'd9, 1'b0); tick(); chk();
`else
    for (int i = 1; i <= 8; i++) begin
      push("bp_disabled_run", 2'b01, 3'(i % 8), (i == 8) ? 4'd9 : 4'd8, 1'b0); tick(); chk();
    end
`endif

    // asynchronous reset at phase 3
    for (int i = 1; i <= 3; i++) begin
      push("pre_rst", 2'b01, 3'(i), 4'd9, 1'b0); tick(); chk();
    end
    #2 rst = 1'b1; bp_valid = 1'b0;
    #1 push("rst_mid", 2'b00, 3'd0, 4'd0, 1'b0); chk();
    tick(); rst = 1'b0;
    start = 1'b1; step = 1'b1;
    push("start_step", 2'b01, 3'd0, 4'd0, 1'b0); tick(); start = 1'b0; step = 1'b0; chk();

    // start+stop together from IDLE: stop ignored
    rst = 1'b1; tick(); rst = 1'b0;
    push("rst2", 2'b00, 3'd0, 4'd0, 1'b0); chk();
    start = 1'b1; stop = 1'b1;
    push("start_stop", 2'b01, 3'd0, 4'd0, 1'b0); tick(); start = 1'b0; stop = 1'b0; chk();
    for (int i = 1; i <= 7; i++) begin
      push("ss_run", 2'b01, 3'(i), 4'd0, 1'b0); tick(); chk();
    end
    push("start_stop_nohalt", 2'b01, 3'd0, 4'd1, 1'b0); tick(); chk();

    // retired-instruction counter wraps at 2^4
    for (int k = 2; k <= 16; k++) begin
      repeat (7) tick();
      push("cnt_wrap", 2'b01, 3'd0, 4'(k), 1'b0); tick(); chk();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_control.md
# run_control

Run/step/halt sequencer for the VeriRisc-style CPU. It owns the 3-bit instruction phase counter that drives the opcode/phase decode controller, and provides start, single-step, stop and optional breakpoint control. It also provides a datapath clock-enable and a retired-instruction counter. It sits between the debug/top-level control inputs and the controller/datapath.

## Interface
Parameters:
- AWIDTH, 5, width of program-counter address compared for breakpoints
- ICNT_WIDTH, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin free run
- step  in  1  single-cycle pulse; execute exactly one instruction
- stop  in  1  single-cycle pulse; halt at end of current instruction
- halt  in  1  halt strobe from controller (meaningful in phase 4 only)
- pc_addr  in  AWIDTH  current PC value from datapath
- bp_addr  in  AWIDTH  breakpoint address
- bp_valid  in  1  breakpoint armed
- phase  out  3  instruction phase to controller
- cpu_en  out  1  datapath register enable; high only while executing
- run_state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- busy  out  1  high in RUN or STEP
- instr_count  out  ICNT_WIDTH  retired-instruction count
- bp_hit  out  1  sticky breakpoint-hit flag

## Operation
- Reset values: run_state IDLE, phase 0, cpu_en 0, busy 0, instr_count 0, bp_hit 0, internal stop_pending 0. rst mid-instruction aborts immediately; no partial completion.
- cpu_en and busy are decoded from run_state only: 1 in RUN/STEP, 0 otherwise.
- IDLE/HALTED:
  - phase held at 0.
  - start -> RUN; step -> STEP; start wins if both are asserted.
  - stop is ignored.
  - Leaving HALTED clears bp_hit.
- RUN/STEP:
  - phase increments every clock, 7 wraps to 0.
  - Boundary = edge where phase goes 7 -> 0; instr_count increments at each boundary and wraps at 2^ICNT_WIDTH.
  - start/step are ignored.
- halt: sampled only when cpu_en=1 and phase=4.
  - Next state HALTED, phase 0, instr_count increments; phases 5-7 are skipped.
  - halt in any other phase is ignored.
- stop in RUN/STEP sets stop_pending. At the next boundary the state goes to HALTED and stop_pending clears. stop_pending also clears on halt.
- STEP: at the boundary, state goes to HALTED unconditionally.
- Breakpoint (RUN only): at a boundary, if bp_valid=1 and pc_addr==bp_addr, state goes to HALTED and bp_hit is set to 1.
  - The check uses PC after phase-4 increment, so the CPU halts before fetching the instruction at bp_addr.
  - Resuming with start executes the bp_addr instruction; no re-hit occurs because the next check sees the incremented PC.
- Simultaneous breakpoint and stop_pending at a boundary: state goes to HALTED, bp_hit=1, stop_pending cleared.

## Timing
- All state, phase and counters are registered; outputs are Moore (no input-to-output combinational path).
- start sampled at edge t: at t+1, run_state=RUN, phase=0, cpu_en=1. phase=7 at t+8; boundary at t+9.
- step at edge t: cpu_en high for exactly 8 cycles; run_state=HALTED from t+9.
- HLT instruction occupies 5 cycles (phases 0-4); HALTED on the edge ending phase 4.
- stop latency: 1-8 cycles depending on the phase at which it arrives; the instruction always completes.
- instr_count and run_state update on the same edge.

## Configuration
- BREAKPOINT_EN defined: breakpoint compare and bp_hit register are implemented as above.
- BREAKPOINT_EN undefined: bp_addr/bp_valid ports remain but are ignored; bp_hit is tied 0; no comparator logic.

## Test plan
- rst, then start pulse -> phase 0,1,...,7,0,... with cpu_en=1, run_state=01; instr_count=1 nine edges after start, 2 after seventeen.
- step from IDLE -> exactly 8 cycles cpu_en=1, then run_state=11, phase=0, instr_count=1; a second step gives instr_count=2.
- RUN with halt=1 during phase 2 -> ignored; halt=1 during phase 4 -> next cycle run_state=11, phase=0, instr_count incremented.
- RUN, stop pulse at phase 2 -> phases 3-7 complete, run_state=11 at boundary; start+stop in the same cycle from IDLE -> RUN, stop ignored.
- BREAKPOINT_EN, bp_valid=1, bp_addr=5, pc_addr=5 at phase 7 -> run_state=11, bp_hit=1; start -> bp_hit=0 next cycle, run resumes; bp_valid=0 -> no halt.
- rst asserted at phase 3 in RUN -> phase=0, run_state=00, instr_count=0 before the next clock edge; start and step together after reset -> run_state=01.
